// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one single-precision compare (lt/eq/le) among NREQ requesters.
// Latency: 1 cycle from the grant edge to res_valid; sustains one result per cycle.
// Backpressure: while a result is held (res_valid && !res_ready) no request is granted and outputs are frozen.
//
// Ports:
//   clk, rstn            clock; synchronous reset, asserted high
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_op/req_x1/req_x2 packed per-requester op (2b) and IEEE-754 operands (32b each)
//   res_valid/res_ready  result handshake; res_y is the compare result, res_id the source requester
module fcmp_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_x1,
    input  logic [32*NREQ-1:0]   req_x2,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_y,
    output logic [IDW-1:0]       res_id
);

    localparam logic [1:0] OP_LT = 2'b00;
    localparam logic [1:0] OP_EQ = 2'b01;
    localparam logic [1:0] OP_LE = 2'b10;

    logic           res_valid_q, res_valid_d;
    logic           res_y_q, res_y_d;
    logic [IDW-1:0] res_id_q, res_id_d;
    logic [IDW-1:0] rr_q, rr_d;

    logic           can_accept;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] cand;
    int             sum;

    logic [1:0]     op_g;
    logic [31:0]    x1_g, x2_g;
    logic           bz, lt, eq, cmp_y;

    assign can_accept = !res_valid_q || res_ready;

    // Search from rr upward with wrap; the first valid hit wins. Reset
    // suppresses the grant so nothing is accepted in the reset cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        sum     = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(rr_q) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            cand = IDW'(sum);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!can_accept || rstn) gnt_vld = 1'b0;
    end

    assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    // Operand mux for the granted requester.
    always_comb begin
        op_g = '0;
        x1_g = '0;
        x2_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_g = req_op[2*i +: 2];
                x1_g = req_x1[32*i +: 32];
                x2_g = req_x2[32*i +: 32];
            end
        end
    end

    // Sign-magnitude compare; zeros and denormals collapse to a single zero.
    always_comb begin
        bz = (x1_g[30:23] == 8'd0) && (x2_g[30:23] == 8'd0);
        lt = !bz && (( x1_g[31] && !x2_g[31]) ||
                     ( x1_g[31] &&  x2_g[31] && (x1_g[30:0] > x2_g[30:0])) ||
                     (!x1_g[31] && !x2_g[31] && (x1_g[30:0] < x2_g[30:0])));
        eq = bz || (x1_g == x2_g);
        case (op_g)
            OP_LT:   cmp_y = lt;
            OP_EQ:   cmp_y = eq;
            OP_LE:   cmp_y = lt || eq;
            default: cmp_y = 1'b0;
        endcase
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_id_d    = res_id_q;
        rr_d        = rr_q;
        if (gnt_vld) begin
            // A grant overwrites any result being consumed on the same edge.
            res_valid_d = 1'b1;
            res_y_d     = cmp_y;
            res_id_d    = gnt_idx;
            rr_d        = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            res_valid_q <= 1'b0;
            res_y_q     <= 1'b0;
            res_id_q    <= '0;
            rr_q        <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_id_q    <= res_id_d;
            rr_q        <= rr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Testbench for fcmp_arbiter: scenario tasks with a queue scoreboard of expected results.
// Latency: results are checked one cycle after their grant.
// Backpressure: exercised by holding res_ready low with a pending result.
module tb_fcmp_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [2*NREQ-1:0]    req_op;
    logic [32*NREQ-1:0]   req_x1;
    logic [32*NREQ-1:0]   req_x2;
    logic                 res_valid;
    logic                 res_ready;
    logic                 res_y;
    logic [IDW-1:0]       res_id;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           y;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   failures;

    fcmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*i +: 2]  = op;
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
    endtask

    task automatic push(input int id, input logic y);
        exp_t n;
        n.id = IDW'(id);
        n.y  = y;
        sb.push_back(n);
    endtask

    task automatic test_reset();
        rstn = 1'b1; res_ready = 1'b1; req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        step();
        rstn = 1'b0; req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || res_y !== 1'b0 || res_id !== 2'd0) begin
            failures++; $display("FAIL reset_state got v=%b y=%b id=%0d exp v=0 y=0 id=0", res_valid, res_y, res_id);
        end
    endtask

    task automatic test_single();
        set_req(0, 2'b00, 32'hBF800000, 32'h3F800000);
        req_valid = 4'b0001; res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        push(0, 1'b1);
        step();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL single_latency got valid=%b exp valid=1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_y !== e.y || res_id !== e.id) begin
                failures++; $display("FAIL single_result got y=%b id=%0d exp y=%b id=%0d", res_y, res_id, e.y, e.id);
            end
        end
        step();
        #1;
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL single_drain got valid=%b exp valid=0", res_valid); end
    endtask

    // Back-to-back compare table; requester rotates to exercise the operand mux.
    task automatic test_compare();
        logic [1:0]  ops [10];
        logic [31:0] a   [10];
        logic [31:0] b   [10];
        logic        ys  [10];
        int          r;
        ops[0]=2'b00; a[0]=32'h80000000; b[0]=32'h00000000; ys[0]=1'b0;
        ops[1]=2'b01; a[1]=32'h80000000; b[1]=32'h00000000; ys[1]=1'b1;
        ops[2]=2'b10; a[2]=32'h00000001; b[2]=32'h00000000; ys[2]=1'b1;
        ops[3]=2'b00; a[3]=32'hC0000000; b[3]=32'hBF800000; ys[3]=1'b1;
        ops[4]=2'b00; a[4]=32'h40000000; b[4]=32'h3F800000; ys[4]=1'b0;
        ops[5]=2'b10; a[5]=32'h3F800000; b[5]=32'h3F800000; ys[5]=1'b1;
        ops[6]=2'b11; a[6]=32'hBF800000; b[6]=32'h3F800000; ys[6]=1'b0;
        ops[7]=2'b00; a[7]=32'h3F800000; b[7]=32'h40000000; ys[7]=1'b1;
        ops[8]=2'b01; a[8]=32'h3F800000; b[8]=32'h40000000; ys[8]=1'b0;
        ops[9]=2'b00; a[9]=32'h3F800000; b[9]=32'hBF800000; ys[9]=1'b0;
        res_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            req_valid = '0;
            if (k < 10) begin
                r = k % NREQ;
                set_req(r, ops[k], a[k], b[k]);
                req_valid[r] = 1'b1;
            end
            #1;
            if (k > 0) begin
                checks++;
                if (res_valid !== 1'b1 || sb.size() == 0) begin
                    failures++; $display("FAIL cmp_valid case=%0d got valid=%b exp valid=1", k-1, res_valid);
                end else begin
                    e = sb.pop_front();
                    if (res_y !== e.y || res_id !== e.id) begin
                        failures++; $display("FAIL cmp_result case=%0d got y=%b id=%0d exp y=%b id=%0d", k-1, res_y, res_id, e.y, e.id);
                    end
                end
            end
            if (k < 10) begin
                checks++;
                if (req_ready !== (4'b0001 << r)) begin
                    failures++; $display("FAIL cmp_ready case=%0d got=%b exp=%b", k, req_ready, 4'b0001 << r);
                end
                push(r, ys[k]);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        rstn = 1'b1; req_valid = '0;
        step();
        rstn = 1'b0;
        sb.delete();
        // Even requesters compare 1<2 (true), odd ones 1<0.5 (false).
        for (int i = 0; i < NREQ; i++)
            set_req(i, 2'b00, 32'h3F800000, (i % 2 == 0) ? 32'h40000000 : 32'h3F000000);
        req_valid = '1; res_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            if (c == 5) req_valid = '0;
            #1;
            if (c > 0) begin
                checks++;
                if (res_valid !== 1'b1 || sb.size() == 0) begin
                    failures++; $display("FAIL rr_valid cycle=%0d got valid=%b exp valid=1", c, res_valid);
                end else begin
                    e = sb.pop_front();
                    if (res_y !== e.y || res_id !== e.id) begin
                        failures++; $display("FAIL rr_result cycle=%0d got y=%b id=%0d exp y=%b id=%0d", c, res_y, res_id, e.y, e.id);
                    end
                end
            end
            if (c < 5) begin
                checks++;
                if (req_ready !== (4'b0001 << (c % NREQ))) begin
                    failures++; $display("FAIL rr_grant cycle=%0d got=%b exp=%b", c, req_ready, 4'b0001 << (c % NREQ));
                end
                push(c % NREQ, (c % 2 == 0));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        set_req(0, 2'b00, 32'hBF800000, 32'h3F800000);
        set_req(1, 2'b00, 32'h40000000, 32'h3F800000);
        set_req(2, 2'b01, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0001; res_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_setup got=%b exp=0001", req_ready); end
        push(0, 1'b1);
        step();
        req_valid = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || res_valid !== 1'b1 || sb.size() == 0 ||
                res_y !== sb[0].y || res_id !== sb[0].id) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got ready=%b v=%b y=%b id=%0d exp ready=0000 v=1 y=1 id=0",
                         c, req_ready, res_valid, res_y, res_id);
            end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL bp_pop got valid=%b exp valid=1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_y !== e.y || res_id !== e.id) begin
                failures++; $display("FAIL bp_result got y=%b id=%0d exp y=%b id=%0d", res_y, res_id, e.y, e.id);
            end
        end
        push(1, 1'b0);
        step();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL bp_next got valid=%b exp valid=1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_y !== e.y || res_id !== e.id) begin
                failures++; $display("FAIL bp_next_result got y=%b id=%0d exp y=%b id=%0d", res_y, res_id, e.y, e.id);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        // rr is 2 here; granting requester 1 again leaves rr=2 with a result held.
        req_valid = 4'b0010; res_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_mid_setup got=%b exp=0010", req_ready); end
        push(1, 1'b0);
        step();
        set_req(0, 2'b10, 32'h00000000, 32'h80000000);
        set_req(2, 2'b00, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0101; res_ready = 1'b1; rstn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL rst_mid_ready got=%b exp=0000", req_ready); end
        step();
        sb.delete();
        rstn = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_discard got valid=%b exp valid=0", res_valid); end
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL rst_mid_rr got=%b exp=0001", req_ready); end
        push(0, 1'b1);
        step();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL rst_mid_valid got valid=%b exp valid=1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_y !== e.y || res_id !== e.id) begin
                failures++; $display("FAIL rst_mid_result got y=%b id=%0d exp y=%b id=%0d", res_y, res_id, e.y, e.id);
            end
        end
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL rst_mid_second got=%b exp=0100", req_ready); end
        push(2, 1'b0);
        step();
        req_valid = '0;
        #1;
        checks++;
        if (res_valid !== 1'b1 || sb.size() == 0) begin
            failures++; $display("FAIL rst_mid_last got valid=%b exp valid=1", res_valid);
        end else begin
            e = sb.pop_front();
            if (res_y !== e.y || res_id !== e.id) begin
                failures++; $display("FAIL rst_mid_last_result got y=%b id=%0d exp y=%b id=%0d", res_y, res_id, e.y, e.id);
            end
        end
        step();
    endtask

    initial begin
        checks = 0; failures = 0;
        rstn = 1'b1; req_valid = '0; res_ready = 1'b0;
        req_op = '0; req_x1 = '0; req_x2 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_compare();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_empty got=%0d exp=0 leftover results", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
